// File: rtl/core_pkg.sv
// Shared core definitions: architectural sizes, register-file types and FSM encoding.
package core_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam reg_addr_t REG_ZERO = reg_addr_t'(0);
  localparam reg_addr_t REG_SP   = reg_addr_t'(2);

endpackage : core_pkg

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports with write bypass, one write port,
// and a post-reset scrub that defines every entry before ready is raised.
module reg_file
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] SP_INIT = 32'h0000_3FFC,
  parameter bit              BYPASS  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  output logic            ready
);

  rf_state_e state, state_nxt;
  reg_addr_t ptr, ptr_nxt;
  logic      ready_nxt;
  word_t     storage [NREGS];

  // NOTE: control registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SCRUB;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      ready <= ready_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    ready_nxt = ready;
    case (state)
      SCRUB: begin
        ptr_nxt = ptr + reg_addr_t'(1);
        if (ptr == reg_addr_t'(NREGS - 1)) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end
      end
      RUN:     ;
      default: state_nxt = SCRUB;
    endcase
  end

  // NOTE: the array has no reset branch; the scrub walk defines its contents instead,
  // which keeps it mappable onto plain RAM/latch-array cells.
  // x0 is scrubbed to zero like the rest but is never read, so user writes skip it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == SCRUB) begin
        storage[ptr] <= (ptr == REG_SP) ? SP_INIT : '0;
      end else if (we && (rd_addr != REG_ZERO)) begin
        storage[rd_addr] <= rd_data;
      end
    end
  end

  always_comb begin
    rs1_data = '0;
    if ((state == RUN) && (rs1_addr != REG_ZERO)) begin
      if (BYPASS && we && (rd_addr == rs1_addr)) rs1_data = rd_data;
      else                                         rs1_data = storage[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if ((state == RUN) && (rs2_addr != REG_ZERO)) begin
      if (BYPASS && we && (rd_addr == rs2_addr)) rs2_data = rd_data;
      else                                         rs2_data = storage[rs2_addr];
    end
  end

endmodule : reg_file
